// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer for a PRBS31 generator: seeds once, then alternates enable
// bursts and idle gaps, with single-shot error-injection strobes.
module prbs_burst_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] burst_len,
   input  logic [CNT_W-1:0] gap_len,
   input  logic [3:0]       num_bursts,
   input  logic             err_inj,
   output logic             prbs_load,
   output logic             prbs_en,
   output logic             err_flip,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [7:0]       burst_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_GAP, S_DONE} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] blen_q, glen_q;
   logic [3:0]       nb_q;
   logic [7:0]       bcnt_nxt, bcnt_inc;
   logic             pend, pend_nxt;
   logic             abort_nxt;
   logic             accept;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         blen_q    <= '0;
         glen_q    <= '0;
         nb_q      <= '0;
         burst_cnt <= '0;
         pend      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         burst_cnt <= bcnt_nxt;
         pend      <= pend_nxt;
         aborted   <= abort_nxt;
         if (accept) begin
            blen_q <= burst_len;
            glen_q <= gap_len;
            nb_q   <= num_bursts;
         end
      end
   end

   // cnt is a down-counter loaded with (length-1) on entry to RUN or GAP
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bcnt_nxt  = burst_cnt;
      bcnt_inc  = burst_cnt + 8'd1;
      abort_nxt = 1'b0;
      accept    = 1'b0;

      prbs_load = (state == S_SEED);
      prbs_en   = (state == S_RUN);
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      err_flip  = (state == S_RUN) && pend;

      case (state)
         S_IDLE: begin
            if (start && !stop && (burst_len != '0)) begin
               accept    = 1'b1;
               state_nxt = S_SEED;
               bcnt_nxt  = '0;
            end
         end
         S_SEED: begin
            state_nxt = S_RUN;
            cnt_nxt   = blen_q - ONE;
         end
         S_RUN: begin
            if (cnt == '0) begin
               bcnt_nxt = bcnt_inc;
               if ((nb_q != 4'd0) && (bcnt_inc == {4'd0, nb_q})) begin
                  state_nxt = S_DONE;
               end else if (glen_q == '0) begin
                  cnt_nxt = blen_q - ONE;
               end else begin
                  state_nxt = S_GAP;
                  cnt_nxt   = glen_q - ONE;
               end
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         S_GAP: begin
            if (cnt == '0) begin
               state_nxt = S_RUN;
               cnt_nxt   = blen_q - ONE;
            end else begin
               cnt_nxt = cnt - ONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // An abort leaves burst_cnt at the last completed burst
      if (stop && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         bcnt_nxt  = burst_cnt;
         abort_nxt = 1'b1;
      end

      // A request in the same cycle as a flip re-arms for the next one
      pend_nxt = (state_nxt == S_IDLE) ? 1'b0 : (err_inj | (pend & ~err_flip));
   end

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl: expected waveforms are built from burst/gap
// arithmetic and compared cycle by cycle with randomized parameters.
module tb_prbs_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, err_inj;
   logic [7:0] burst_len, gap_len;
   logic [3:0] num_bursts;
   logic       prbs_load, prbs_en, err_flip, busy, done, aborted;
   logic [7:0] burst_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit load;
      bit en;
      bit done;
      bit busy;
      int bcnt;
   } exp_t;

   prbs_burst_ctrl #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts),
      .err_inj(err_inj), .prbs_load(prbs_load), .prbs_en(prbs_en),
      .err_flip(err_flip), .busy(busy), .done(done), .aborted(aborted),
      .burst_cnt(burst_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   // One full sequence; optional noise drives start with junk while busy.
   task automatic run_seq(input string name, input int blen, input int glen, input int nb,
                          input bit noise);
      exp_t q[$];
      exp_t e;
      int bad, flips, aborts;
      logic [3:0] act_v;
      logic [7:0] act_c;
      e = '{1, 0, 0, 1, 0};
      q.push_back(e);
      for (int b = 0; b < nb; b++) begin
         for (int i = 0; i < blen; i++) begin
            e = '{0, 1, 0, 1, b};
            q.push_back(e);
         end
         if (b < nb - 1)
            for (int i = 0; i < glen; i++) begin
               e = '{0, 0, 0, 1, b + 1};
               q.push_back(e);
            end
      end
      e = '{0, 0, 1, 1, nb};
      q.push_back(e);
      e = '{0, 0, 0, 0, nb};
      q.push_back(e);

      bad = -1; flips = 0; aborts = 0; act_v = '0; act_c = '0;
      @(negedge clk);
      start = 1'b1; burst_len = 8'(blen); gap_len = 8'(glen); num_bursts = 4'(nb);
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         if (({prbs_load, prbs_en, done, busy} !==
              {q[k].load, q[k].en, q[k].done, q[k].busy}) ||
             (burst_cnt !== 8'(q[k].bcnt))) begin
            if (bad < 0) begin
               bad = k; act_v = {prbs_load, prbs_en, done, busy}; act_c = burst_cnt;
            end
         end
         if (err_flip) flips++;
         if (aborted) aborts++;
         if (noise && (k < q.size() - 2)) begin
            start = 1'($urandom);
            burst_len = 8'($urandom);
            gap_len = 8'($urandom);
            num_bursts = 4'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;

      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s_wave cycle=%0d got load/en/done/busy=%b cnt=%0d want %b cnt=%0d",
                  name, bad, act_v, act_c,
                  {q[bad].load, q[bad].en, q[bad].done, q[bad].busy}, q[bad].bcnt);
      end
      checks++;
      if (flips !== 0) begin
         failures++;
         $display("FAIL %s_flip got %0d err_flip cycles want 0", name, flips);
      end
      checks++;
      if (aborts !== 0) begin
         failures++;
         $display("FAIL %s_abort got %0d aborted cycles want 0", name, aborts);
      end
   endtask

   // Sequence with an err_inj pattern indexed by cycle since the start edge.
   task automatic drive_err_seq(input int blen, input int glen, input int nb,
                                input logic [63:0] inj, output int flips,
                                output int first, output int second, output int stray);
      int len;
      len = 3 + nb * blen + (nb - 1) * glen;
      flips = 0; first = -1; second = -1; stray = 0;
      @(negedge clk);
      start = 1'b1; burst_len = 8'(blen); gap_len = 8'(glen); num_bursts = 4'(nb);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (err_flip) begin
            flips++;
            if (first < 0) first = k;
            else if (second < 0) second = k;
            if (!prbs_en) stray++;
         end
         err_inj = inj[k];
      end
      err_inj = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; start = 1'b0; stop = 1'b0; err_inj = 1'b0;
      burst_len = '0; gap_len = '0; num_bursts = '0;
      #1;
      checks++;
      if ({prbs_load, prbs_en, err_flip, busy, done, aborted, burst_cnt} !== 14'd0) begin
         failures++;
         $display("FAIL reset_async got %b want 0",
                  {prbs_load, prbs_en, err_flip, busy, done, aborted, burst_cnt});
      end
      start = 1'b1; burst_len = 8'd4;
      repeat (2) @(negedge clk);
      checks++;
      if ({prbs_load, busy, burst_cnt} !== 10'd0) begin
         failures++;
         $display("FAIL reset_held got %b want 0", {prbs_load, busy, burst_cnt});
      end
      start = 1'b0;
      rst_n = 1'b0;
   endtask

   task automatic test_random;
      for (int n = 0; n < 6; n++)
         run_seq("random", int'($urandom_range(1, 10)), int'($urandom_range(0, 4)),
                 int'($urandom_range(1, 4)), 1'b1);
   endtask

   task automatic test_wrap;
      int bad_i, dones;
      logic [7:0] bad_c;
      bad_i = -1; dones = 0; bad_c = '0;
      @(negedge clk);
      start = 1'b1; burst_len = 8'd1; gap_len = 8'd0; num_bursts = 4'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((prbs_en !== 1'b1 || burst_cnt !== 8'(i % 256)) && bad_i < 0) begin
            bad_i = i; bad_c = burst_cnt;
         end
         if (done) dones++;
      end
      checks++;
      if (bad_i >= 0) begin
         failures++;
         $display("FAIL wrap_cnt run_cycle=%0d got cnt=%0d want %0d", bad_i, bad_c, bad_i % 256);
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL wrap_done got %0d done pulses want 0", dones);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if ({aborted, busy, done, prbs_en} !== 4'b1000) begin
         failures++;
         $display("FAIL wrap_stop got aborted/busy/done/en=%b want 1000",
                  {aborted, busy, done, prbs_en});
      end
      @(negedge clk);
      checks++;
      if ({aborted, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL wrap_after got aborted/busy/done=%b want 000", {aborted, busy, done});
      end
   endtask

   task automatic test_err;
      int flips, first, second, stray, blen, glen;
      logic [63:0] inj;
      // err_inj in IDLE followed by stop must never surface
      @(negedge clk); err_inj = 1'b1;
      @(negedge clk); err_inj = 1'b0; stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      run_seq("err_idle", 2, 1, 2, 1'b0);

      // three requests during a gap coalesce into one flip on the next burst
      blen = int'($urandom_range(1, 4));
      glen = int'($urandom_range(3, 6));
      inj = '0;
      for (int k = 0; k < 3; k++) inj[1 + blen + k] = 1'b1;
      drive_err_seq(blen, glen, 2, inj, flips, first, second, stray);
      checks++;
      if (flips !== 1 || first !== 1 + blen + glen) begin
         failures++;
         $display("FAIL err_gap got flips=%0d at=%0d want 1 at %0d", flips, first, 1 + blen + glen);
      end
      checks++;
      if (stray !== 0) begin
         failures++;
         $display("FAIL err_gap_outside got %0d flips without en want 0", stray);
      end

      // request coinciding with a flip re-arms for the following cycle
      inj = 64'b11;
      drive_err_seq(3, 0, 2, inj, flips, first, second, stray);
      checks++;
      if (flips !== 2 || first !== 1 || second !== 2) begin
         failures++;
         $display("FAIL err_rearm got flips=%0d at %0d,%0d want 2 at 1,2", flips, first, second);
      end

      // pending request dropped by a stop during a gap
      @(negedge clk);
      start = 1'b1; burst_len = 8'd2; gap_len = 8'd4; num_bursts = 4'd0;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      err_inj = 1'b1;
      @(negedge clk);
      err_inj = 1'b0; stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if ({aborted, busy, done} !== 3'b100) begin
         failures++;
         $display("FAIL gap_stop got aborted/busy/done=%b want 100", {aborted, busy, done});
      end
      run_seq("err_stop", 3, 0, 1, 1'b0);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1; burst_len = 8'd5; gap_len = 8'd0; num_bursts = 4'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({prbs_en, busy} !== 2'b11) begin
         failures++;
         $display("FAIL rstmid_pre got en/busy=%b want 11", {prbs_en, busy});
      end
      #2 rst_n = 1'b1;
      #1;
      checks++;
      if ({prbs_load, prbs_en, err_flip, busy, done, aborted, burst_cnt} !== 14'd0) begin
         failures++;
         $display("FAIL rstmid_async got %b want 0",
                  {prbs_load, prbs_en, err_flip, busy, done, aborted, burst_cnt});
      end
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1; burst_len = 8'd0; gap_len = 8'd2; num_bursts = 4'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({prbs_load, busy, aborted, done} !== 4'b0000) begin
            failures++;
            $display("FAIL zero_len cycle=%0d got load/busy/aborted/done=%b want 0000", i,
                     {prbs_load, busy, aborted, done});
         end
      end
      start = 1'b0;
   endtask

   task automatic test_start_stop;
      @(negedge clk);
      start = 1'b1; stop = 1'b1; burst_len = 8'd4; gap_len = 8'd1; num_bursts = 4'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({prbs_load, busy, aborted} !== 3'b000) begin
            failures++;
            $display("FAIL start_stop cycle=%0d got load/busy/aborted=%b want 000", i,
                     {prbs_load, busy, aborted});
         end
      end
      start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      test_reset;
      run_seq("basic", 4, 2, 2, 1'b0);
      run_seq("back_to_back", 3, 0, 3, 1'b0);
      test_random;
      run_seq("max_len", 255, 1, 2, 1'b0);
      run_seq("single", 1, 0, 1, 1'b0);
      test_wrap;
      test_err;
      test_reset_mid;
      run_seq("after_reset", 2, 1, 2, 1'b0);
      test_start_stop;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs_burst_ctrl.md
PRBS_BURST_CTRL -- requirements
Module: prbs_burst_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of burst_len, gap_len and their internal counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-high reset, despite the name; 1 = reset asserted.
REQ-004 start  input  1  level sampled each clock; begins a sequence when IDLE.
REQ-005 stop  input  1  level sampled each clock; aborts any active sequence.
REQ-006 burst_len  input  CNT_W  enable cycles per burst; latched on accepted start.
REQ-007 gap_len  input  CNT_W  idle cycles between bursts; latched on accepted start.
REQ-008 num_bursts  input  4  bursts per sequence, 0 = run until stop; latched on accepted start.
REQ-009 err_inj  input  1  request one single-bit error injection.
REQ-010 prbs_load  output  1  one-cycle seed-load strobe to the PRBS31 generator.
REQ-011 prbs_en  output  1  advance strobe to the PRBS31 generator.
REQ-012 err_flip  output  1  one-cycle strobe telling the generator to invert its output bit.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on normal sequence completion.
REQ-015 aborted  output  1  one-cycle pulse when stop terminates an active sequence.
REQ-016 burst_cnt  output  8  count of completed bursts in the current or last sequence.

Function
REQ-017 FSM states: IDLE, SEED, RUN, GAP, DONE; all outputs are registered or decoded from the registered state only.
REQ-018 IDLE: start=1, stop=0 and burst_len!=0 -> SEED; burst_cnt cleared to 0 and inputs latched on the same edge; start with burst_len=0 is ignored.
REQ-019 SEED: lasts exactly 1 cycle with prbs_load=1, prbs_en=0, then -> RUN.
REQ-020 RUN: prbs_en=1 for exactly latched burst_len consecutive cycles; burst_cnt increments by 1 on the edge leaving the last RUN cycle.
REQ-021 At burst end: if num_bursts!=0 and the incremented burst_cnt equals num_bursts -> DONE; else if gap_len=0 -> RUN again (back-to-back, no dead cycle); else -> GAP.
REQ-022 GAP: prbs_en=0 for exactly latched gap_len cycles, then -> RUN; no reseed between bursts.
REQ-023 DONE: lasts 1 cycle with done=1, then -> IDLE.
REQ-024 burst_cnt wraps 255 -> 0 when num_bursts=0; wrap does not terminate the sequence.
REQ-025 stop=1 in SEED, RUN, GAP or DONE -> IDLE on the next edge, aborted=1 for that one cycle after, done not asserted; stop in IDLE has no effect.
REQ-026 start and stop both high in IDLE: stop wins, stay IDLE.
REQ-027 start while busy is ignored; latched parameters do not change mid-sequence.
REQ-028 err_inj=1 sets a pending flag; err_flip=1 on the first RUN cycle (prbs_en=1) after the flag is set, flag cleared on that edge.
REQ-029 Multiple err_inj requests while pending coalesce into one err_flip; err_inj in the same cycle as an err_flip re-arms the flag.
REQ-030 Pending flag cleared on stop, on entry to IDLE and on reset; err_flip never asserts outside RUN.
REQ-031 Per-burst prbs_en high-cycle count equals latched burst_len exactly, including burst_len = 2^CNT_W-1.

Reset
REQ-032 While rst_n=1: state IDLE, all outputs 0, burst_cnt=0, counters and pending flag 0, asynchronously without a clock edge.
REQ-033 Reset asserted mid-sequence takes effect immediately; no done or aborted pulse is generated.
REQ-034 After rst_n falls, the first start is accepted on the next rising edge.

Verification
REQ-035 burst_len=4, gap_len=2, num_bursts=2, start 1 cycle -> prbs_load 1 cycle, en 4 on / 2 off / 4 on, done pulse, burst_cnt=2, busy low after.
REQ-036 burst_len=3, gap_len=0, num_bursts=3 -> prbs_en high 9 consecutive cycles, no gaps, done once, burst_cnt=3.
REQ-037 num_bursts=0, burst_len=1, gap_len=0, run 300 cycles then stop -> burst_cnt wraps through 0, aborted pulse, no done, busy low next cycle.
REQ-038 err_inj pulsed 3 times during GAP -> exactly one err_flip on first cycle of next RUN; err_inj while IDLE then stop -> no err_flip ever.
REQ-039 rst_n asserted mid-RUN between clock edges -> all outputs 0 immediately; start=1,burst_len=0 -> stays IDLE.
REQ-040 start and stop high together in IDLE -> no prbs_load, busy stays 0.
